multcyc_ctrl_unit: RTL and testbench

- Next-generation multicycle MIPS control unit: a Moore FSM that sequences fetch, decode, execute, memory and writeback and drives all datapath mux selects and write enables.
- Adds the immediate-logical group (ANDI, ORI, XORI, SLTI, SLTIU, LUI), BNE and J to the current LW/SW/RR/BEQ/ADDI/ADDIU set.
- Supports a variable-latency memory through a req/ready handshake with a timeout.
- Traps unknown opcodes.
- Sits between the instruction register opcode field and the multicycle datapath.

---
 rtl/multcyc_ctrl_unit_pkg.sv | 47 ++++
 rtl/multcyc_ctrl_unit_mem_wait_timer.sv | 27 ++
 rtl/multcyc_ctrl_unit.sv | 190 +++++++++++++++++++
 tb/tb_multcyc_ctrl_unit.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multcyc_ctrl_unit_pkg.sv
// rtl/multcyc_ctrl_unit_pkg.sv - opcodes, select types and FSM states for the multicycle control unit
package multcyc_ctrl_unit_pkg;

   localparam logic [5:0] OpRR    = 6'b000000;
   localparam logic [5:0] OpJ     = 6'b000010;
   localparam logic [5:0] OpBEQ   = 6'b000100;
   localparam logic [5:0] OpBNE   = 6'b000101;
   localparam logic [5:0] OpADDI  = 6'b001000;
   localparam logic [5:0] OpADDIU = 6'b001001;
   localparam logic [5:0] OpSLTI  = 6'b001010;
   localparam logic [5:0] OpSLTIU = 6'b001011;
   localparam logic [5:0] OpANDI  = 6'b001100;
   localparam logic [5:0] OpORI   = 6'b001101;
   localparam logic [5:0] OpXORI  = 6'b001110;
   localparam logic [5:0] OpLUI   = 6'b001111;
   localparam logic [5:0] OpLW    = 6'b100011;
   localparam logic [5:0] OpSW    = 6'b101011;

   typedef enum logic       {AddrPC, AddrALUout} mem_addr_sel_t;
   typedef enum logic [1:0] {PcALU, PcALUout, PcJump} pc_src_t;
   typedef enum logic       {SrcaPC, SrcaRs} alu_srca_sel_t;
   typedef enum logic [1:0] {SrcbRt, Four, SrcbImm, SrcbImmSh2} alu_srcb_sel_t;
   typedef enum logic [3:0] {ALUop_ADD, ALUop_SUB, ALUop_RR, ALUop_ADDU, ALUop_AND, ALUop_OR,
                             ALUop_XOR, ALUop_SLT, ALUop_SLTU, ALUop_LUI} ALUop_t;
   typedef enum logic       {WrRt, WrRd} wreg_dst_sel_t;
   typedef enum logic       {ALUout, MemData} wrbck_data_sel_t;

   typedef enum logic [4:0] {Fetch, Decode, MemAddr, MemRd, MemWrbck, MemWr, RRExec, ALURRWrbck,
                             Beq, Bne, Jump, ImmExec, ALURIWrbck, Trap} state_type;

   // ALU operation for the immediate-arithmetic/logical group
   function automatic ALUop_t immAluOp(input logic [5:0] op);
      ALUop_t res;
      case (op)
         OpADDIU: res = ALUop_ADDU;
         OpANDI:  res = ALUop_AND;
         OpORI:   res = ALUop_OR;
         OpXORI:  res = ALUop_XOR;
         OpSLTI:  res = ALUop_SLT;
         OpSLTIU: res = ALUop_SLTU;
         OpLUI:   res = ALUop_LUI;
         default: res = ALUop_ADD;
      endcase
      return res;
   endfunction

endpackage

// File: rtl/multcyc_ctrl_unit_mem_wait_timer.sv
// rtl/multcyc_ctrl_unit_mem_wait_timer.sv - counts stalled memory cycles and flags the timeout
module mem_wait_timer #(
   parameter int TIMEOUT = 64
) (
   input  logic clk,
   input  logic rst_n,
   input  logic waiting,
   output logic timeout
);

   logic [9:0] waitCnt;

   // The last tolerated stall cycle is the one where the count already equals TIMEOUT-1
   assign timeout = waiting && (waitCnt == 10'(TIMEOUT - 1));

   // Count consecutive stalled cycles; any non-stalled cycle or a timeout restarts from zero
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         waitCnt <= '0;
      end else if (!waiting || timeout) begin
         waitCnt <= '0;
      end else begin
         waitCnt <= waitCnt + 10'd1;
      end
   end

endmodule

// File: rtl/multcyc_ctrl_unit.sv
// rtl/multcyc_ctrl_unit.sv - Moore FSM sequencing the multicycle MIPS datapath
module multcyc_ctrl_unit
   import multcyc_ctrl_unit_pkg::*;
#(
   parameter bit MEM_HANDSHAKE = 1'b1,
   parameter bit EN_LOGIC_IMM  = 1'b1,
   parameter bit EN_BNE_J      = 1'b1,
   parameter int TIMEOUT       = 64
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       mem_addr_sel,
   output logic       ir_we,
   output logic       pc_we,
   output logic [1:0] pc_src,
   output logic       alu_srca_sel,
   output logic [1:0] alu_srcb_sel,
   output logic       imm_zext,
   output logic [3:0] alu_op,
   output logic       reg_we,
   output logic       wreg_dst_sel,
   output logic       wrbck_data_sel,
   output logic       illegal_op,
   output logic       mem_err,
   output logic [4:0] state_o
);

   state_type       state, nextState;
   logic            memReady, waiting, timeout;
   logic            isLogicImm, isZext;
   logic            memReq, memWe, irWe, pcWe, regWe, zext;
   mem_addr_sel_t   addrSel;
   pc_src_t         pcSrc;
   alu_srca_sel_t   srcA;
   alu_srcb_sel_t   srcB;
   ALUop_t          aluOp;
   wreg_dst_sel_t   dstSel;
   wrbck_data_sel_t wbSel;
   logic            illegalOp, memErr;

   assign memReady   = MEM_HANDSHAKE ? mem_ready : 1'b1;
   assign waiting    = (state == Fetch || state == MemRd || state == MemWr) && !memReady;
   assign isLogicImm = EN_LOGIC_IMM && (opcode == OpANDI || opcode == OpORI || opcode == OpXORI ||
                       opcode == OpSLTI || opcode == OpSLTIU || opcode == OpLUI);
   assign isZext     = opcode == OpANDI || opcode == OpORI || opcode == OpXORI;

   mem_wait_timer #(.TIMEOUT(TIMEOUT)) uTimer (
      .clk     (clk),
      .rst_n   (rst_n),
      .waiting (waiting),
      .timeout (timeout)
   );

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= Fetch;
      else        state <= nextState;
   end

   // Sticky error flags: undecodable opcode and memory handshake timeout
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         illegalOp <= 1'b0;
         memErr    <= 1'b0;
      end else begin
         if (state == Decode && nextState == Trap) illegalOp <= 1'b1;
         if (timeout) memErr <= 1'b1;
      end
   end

   // Next-state and per-state datapath controls
   always_comb begin
      nextState = state;
      memReq    = 1'b0;
      memWe     = 1'b0;
      irWe      = 1'b0;
      pcWe      = 1'b0;
      regWe     = 1'b0;
      zext      = 1'b0;
      addrSel   = AddrPC;
      pcSrc     = PcALU;
      srcA      = SrcaPC;
      srcB      = SrcbRt;
      aluOp     = ALUop_ADD;
      dstSel    = WrRt;
      wbSel     = ALUout;
      case (state)
         Fetch: begin
            memReq = 1'b1;
            srcB   = Four;
            irWe   = memReady;
            pcWe   = memReady;
            if (memReady)     nextState = Decode;
            else if (timeout) nextState = Trap;
         end
         Decode: begin
            srcB = SrcbImmSh2;
            if (opcode == OpLW || opcode == OpSW)        nextState = MemAddr;
            else if (opcode == OpRR)                     nextState = RRExec;
            else if (opcode == OpBEQ)                    nextState = Beq;
            else if (EN_BNE_J && opcode == OpBNE)        nextState = Bne;
            else if (EN_BNE_J && opcode == OpJ)          nextState = Jump;
            else if (opcode == OpADDI || opcode == OpADDIU || isLogicImm) nextState = ImmExec;
            else                                         nextState = Trap;
         end
         MemAddr: begin
            srcA      = SrcaRs;
            srcB      = SrcbImm;
            nextState = (opcode == OpLW) ? MemRd : MemWr;
         end
         MemRd: begin
            memReq  = 1'b1;
            addrSel = AddrALUout;
            if (memReady)     nextState = MemWrbck;
            else if (timeout) nextState = Trap;
         end
         MemWrbck: begin
            regWe     = 1'b1;
            wbSel     = MemData;
            nextState = Fetch;
         end
         MemWr: begin
            memReq  = 1'b1;
            memWe   = 1'b1;
            addrSel = AddrALUout;
            if (memReady)     nextState = Fetch;
            else if (timeout) nextState = Trap;
         end
         RRExec: begin
            srcA      = SrcaRs;
            aluOp     = ALUop_RR;
            nextState = ALURRWrbck;
         end
         ALURRWrbck: begin
            regWe     = 1'b1;
            dstSel    = WrRd;
            nextState = Fetch;
         end
         Beq, Bne: begin
            srcA      = SrcaRs;
            aluOp     = ALUop_SUB;
            pcSrc     = PcALUout;
            pcWe      = (state == Beq) ? zero : !zero;
            nextState = Fetch;
         end
         Jump: begin
            pcSrc     = PcJump;
            pcWe      = 1'b1;
            nextState = Fetch;
         end
         ImmExec, ALURIWrbck: begin
            srcA  = SrcaRs;
            srcB  = SrcbImm;
            aluOp = immAluOp(opcode);
            zext  = isZext;
            if (state == ALURIWrbck) begin
               regWe     = 1'b1;
               nextState = Fetch;
            end else begin
               nextState = ALURIWrbck;
            end
         end
         Trap: nextState = Trap;
         default: nextState = Trap;
      endcase
   end

   assign mem_req        = rst_n && memReq;
   assign mem_we         = rst_n && memWe;
   assign ir_we          = rst_n && irWe;
   assign pc_we          = rst_n && pcWe;
   assign reg_we         = rst_n && regWe;
   assign imm_zext       = rst_n && zext;
   assign mem_addr_sel   = rst_n ? addrSel : AddrPC;
   assign pc_src         = rst_n ? pcSrc : PcALU;
   assign alu_srca_sel   = rst_n ? srcA : SrcaPC;
   assign alu_srcb_sel   = rst_n ? srcB : SrcbRt;
   assign alu_op         = rst_n ? aluOp : ALUop_ADD;
   assign wreg_dst_sel   = rst_n ? dstSel : WrRt;
   assign wrbck_data_sel = rst_n ? wbSel : ALUout;
   assign illegal_op     = illegalOp;
   assign mem_err        = memErr;
   assign state_o        = state;

endmodule

// File: tb/tb_multcyc_ctrl_unit.sv
// tb/tb_multcyc_ctrl_unit.sv - bench for multcyc_ctrl_unit with an instruction-level reference model
module tb_multcyc_ctrl_unit;
   import multcyc_ctrl_unit_pkg::*;

   localparam int TMO = 8;
   // lane 0: full feature set with handshake; lane 1: fixed-latency memory, extensions disabled
   localparam logic [1:0] HS   = 2'b01;
   localparam logic [1:0] ENLI = 2'b01;
   localparam logic [1:0] ENBJ = 2'b01;

   typedef struct packed {
      logic       memReq, memWe, addrSel, irWe, pcWe;
      logic [1:0] pcSrc;
      logic       srcA;
      logic [1:0] srcB;
      logic       zext;
      logic [3:0] aluOp;
      logic       regWe, dstSel, wbSel, illegal, memErr;
      logic [4:0] st;
   } outs_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [1:0][5:0] opc;
   logic [1:0] rdy, zr;
   outs_t oA, oB;
   int total = 0;
   int bad = 0;

   always #5 clk = ~clk;

   multcyc_ctrl_unit #(.MEM_HANDSHAKE(1'b1), .EN_LOGIC_IMM(1'b1), .EN_BNE_J(1'b1), .TIMEOUT(TMO)) dutA (
      .clk(clk), .rst_n(rst_n), .opcode(opc[0]), .zero(zr[0]), .mem_ready(rdy[0]),
      .mem_req(oA.memReq), .mem_we(oA.memWe), .mem_addr_sel(oA.addrSel), .ir_we(oA.irWe),
      .pc_we(oA.pcWe), .pc_src(oA.pcSrc), .alu_srca_sel(oA.srcA), .alu_srcb_sel(oA.srcB),
      .imm_zext(oA.zext), .alu_op(oA.aluOp), .reg_we(oA.regWe), .wreg_dst_sel(oA.dstSel),
      .wrbck_data_sel(oA.wbSel), .illegal_op(oA.illegal), .mem_err(oA.memErr), .state_o(oA.st));

   multcyc_ctrl_unit #(.MEM_HANDSHAKE(1'b0), .EN_LOGIC_IMM(1'b0), .EN_BNE_J(1'b0), .TIMEOUT(TMO)) dutB (
      .clk(clk), .rst_n(rst_n), .opcode(opc[1]), .zero(zr[1]), .mem_ready(rdy[1]),
      .mem_req(oB.memReq), .mem_we(oB.memWe), .mem_addr_sel(oB.addrSel), .ir_we(oB.irWe),
      .pc_we(oB.pcWe), .pc_src(oB.pcSrc), .alu_srca_sel(oB.srcA), .alu_srcb_sel(oB.srcB),
      .imm_zext(oB.zext), .alu_op(oB.aluOp), .reg_we(oB.regWe), .wreg_dst_sel(oB.dstSel),
      .wrbck_data_sel(oB.wbSel), .illegal_op(oB.illegal), .mem_err(oB.memErr), .state_o(oB.st));

   // ---------------- reference model: per-instruction step lists ----------------
   state_type mPath[2][5];
   int        mLen[2], mPos[2], mWait[2];
   state_type mSt[2];
   logic      mIll[2], mErr[2];

   function automatic void modelReset(input int l);
      mPath[l][0] = Fetch;
      mLen[l] = 1; mPos[l] = 0; mWait[l] = 0;
      mSt[l] = Fetch; mIll[l] = 1'b0; mErr[l] = 1'b0;
   endfunction

   function automatic void addStep(input int l, input state_type s);
      mPath[l][mLen[l]] = s;
      mLen[l] = mLen[l] + 1;
   endfunction

   function automatic void buildRoute(input int l, input logic [5:0] op);
      logic logicImm;
      logicImm = op inside {OpANDI, OpORI, OpXORI, OpSLTI, OpSLTIU, OpLUI};
      mLen[l] = 1;
      addStep(l, Decode);
      if (op == OpLW) begin addStep(l, MemAddr); addStep(l, MemRd); addStep(l, MemWrbck); end
      else if (op == OpSW) begin addStep(l, MemAddr); addStep(l, MemWr); end
      else if (op == OpRR) begin addStep(l, RRExec); addStep(l, ALURRWrbck); end
      else if (op == OpBEQ) addStep(l, Beq);
      else if (op == OpBNE && ENBJ[l]) addStep(l, Bne);
      else if (op == OpJ && ENBJ[l]) addStep(l, Jump);
      else if (op == OpADDI || op == OpADDIU || (logicImm && ENLI[l])) begin
         addStep(l, ImmExec); addStep(l, ALURIWrbck);
      end
      else addStep(l, Trap);
   endfunction

   function automatic void modelStep(input int l);
      logic r;
      r = HS[l] ? rdy[l] : 1'b1;
      if (mSt[l] == Trap) return;
      if ((mSt[l] == Fetch || mSt[l] == MemRd || mSt[l] == MemWr) && !r) begin
         mWait[l] = mWait[l] + 1;
         if (mWait[l] == TMO) begin mErr[l] = 1'b1; mSt[l] = Trap; mWait[l] = 0; end
         return;
      end
      mWait[l] = 0;
      if (mPos[l] == 0) buildRoute(l, opc[l]);
      mPos[l] = mPos[l] + 1;
      if (mPos[l] == mLen[l]) mPos[l] = 0;
      mSt[l] = mPath[l][mPos[l]];
      if (mSt[l] == Trap) mIll[l] = 1'b1;
   endfunction

   function automatic logic [3:0] immAlu(input logic [5:0] op);
      case (op)
         OpADDIU: return ALUop_ADDU;
         OpANDI:  return ALUop_AND;
         OpORI:   return ALUop_OR;
         OpXORI:  return ALUop_XOR;
         OpSLTI:  return ALUop_SLT;
         OpSLTIU: return ALUop_SLTU;
         OpLUI:   return ALUop_LUI;
         default: return ALUop_ADD;
      endcase
   endfunction

   function automatic outs_t expOut(input int l);
      outs_t e;
      logic r;
      r = HS[l] ? rdy[l] : 1'b1;
      e = '0;
      e.st = mSt[l]; e.illegal = mIll[l]; e.memErr = mErr[l];
      case (mSt[l])
         Fetch:      begin e.memReq = 1'b1; e.srcB = Four; e.irWe = r; e.pcWe = r; end
         Decode:     e.srcB = SrcbImmSh2;
         MemAddr:    begin e.srcA = SrcaRs; e.srcB = SrcbImm; end
         MemRd:      begin e.memReq = 1'b1; e.addrSel = AddrALUout; end
         MemWrbck:   begin e.regWe = 1'b1; e.wbSel = MemData; e.dstSel = WrRt; end
         MemWr:      begin e.memReq = 1'b1; e.memWe = 1'b1; e.addrSel = AddrALUout; end
         RRExec:     begin e.srcA = SrcaRs; e.srcB = SrcbRt; e.aluOp = ALUop_RR; end
         ALURRWrbck: begin e.regWe = 1'b1; e.dstSel = WrRd; e.wbSel = ALUout; end
         Beq, Bne: begin
            e.srcA = SrcaRs; e.srcB = SrcbRt; e.aluOp = ALUop_SUB; e.pcSrc = PcALUout;
            e.pcWe = (mSt[l] == Beq) ? zr[l] : !zr[l];
         end
         Jump:       begin e.pcSrc = PcJump; e.pcWe = 1'b1; end
         ImmExec, ALURIWrbck: begin
            e.srcA = SrcaRs; e.srcB = SrcbImm; e.aluOp = immAlu(opc[l]);
            e.zext = opc[l] inside {OpANDI, OpORI, OpXORI};
            e.regWe = (mSt[l] == ALURIWrbck);
         end
         default: ;
      endcase
      return e;
   endfunction

   initial begin
      modelReset(0);
      modelReset(1);
   end

   // Model advances on the same edge as the DUT, from the inputs present at that edge
   always @(posedge clk) begin
      for (int l = 0; l < 2; l++) begin
         if (!rst_n) modelReset(l);
         else        modelStep(l);
      end
   end

   // Cycle-by-cycle comparison of both lanes against the model
   always @(negedge clk) begin
      for (int l = 0; l < 2; l++) begin
         outs_t e, g;
         g = (l == 0) ? oA : oB;
         e = rst_n ? expOut(l) : outs_t'(0);
         total++;
         if (g !== e) begin
            bad++;
            $display("FAIL lane%0d_outputs t=%0t: got=%h expected=%h (state got=%0d expected=%0d)",
                     l, $time, g, e, g.st, e.st);
         end
      end
   end

   // ---------------- directed helpers ----------------
   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic doReset(input logic [5:0] op);
      nextCycle();
      rst_n = 1'b0;
      opc[0] = op; opc[1] = op; rdy = 2'b11; zr = 2'b00;
      nextCycle();
      rst_n = 1'b1;
   endtask

   function automatic logic [5:0] pickOp(input int l);
      logic [5:0] tbl[14] = '{OpLW, OpSW, OpRR, OpBEQ, OpADDI, OpADDIU, OpBNE, OpJ,
                              OpANDI, OpORI, OpXORI, OpSLTI, OpSLTIU, OpLUI};
      int idx;
      if (l == 1 && $urandom_range(0, 3) != 0) idx = $urandom_range(0, 5);
      else idx = $urandom_range(0, 14);
      if (idx == 14) return 6'($urandom_range(0, 63));
      return tbl[idx];
   endfunction

   state_type  lwSeq[6] = '{Fetch, Decode, MemAddr, MemRd, MemWrbck, Fetch};
   logic [5:0] brOp[3]  = '{OpBEQ, OpBNE, OpBNE};
   logic       brZ[3]   = '{1'b1, 1'b1, 1'b0};
   logic       brPc[3]  = '{1'b1, 1'b0, 1'b1};
   state_type  brSt[3]  = '{Beq, Bne, Bne};

   initial begin
      int cnt;
      int stall[2];
      int trapAge;
      opc[0] = OpLW; opc[1] = OpLW; rdy = 2'b11; zr = 2'b00;

      // reset state
      repeat (2) @(posedge clk);
      #1;
      check("reset_outputs_A", oA, 0);
      check("reset_outputs_B", oB, 0);
      rst_n = 1'b1;

      // LW with memory always ready: five-state instruction
      for (int c = 0; c < 6; c++) begin
         if (c > 0) nextCycle();
         @(negedge clk);
         check("lw_state_seq", oA.st, lwSeq[c]);
         if (c == 4) check("lw_wrbck_regwe_memdata", {oA.regWe, oA.wbSel}, 2'b11);
         if (c == 3) check("lw_memrd_regwe", oA.regWe, 0);
      end

      // SW with mem_ready delayed three cycles in MemWr
      doReset(OpSW);
      cnt = 0;
      for (int c = 0; c < 8; c++) begin
         if (c > 0) nextCycle();
         rdy[0] = !(c >= 2 && c <= 5);
         @(negedge clk);
         if (oA.memReq && oA.memWe) cnt++;
         if (c == 7) check("sw_exit_state", oA.st, Fetch);
      end
      check("sw_req_we_cycles", cnt, 4);
      check("sw_mem_err", oA.memErr, 0);

      // branches
      for (int i = 0; i < 3; i++) begin
         doReset(brOp[i]);
         zr[0] = brZ[i];
         for (int c = 0; c < 4; c++) begin
            if (c > 0) nextCycle();
            @(negedge clk);
            if (c == 2) begin
               check("branch_state", oA.st, brSt[i]);
               check("branch_pc_we", oA.pcWe, brPc[i]);
            end
            if (c == 3) check("branch_back_to_fetch", oA.st, Fetch);
         end
      end

      // ORI: zero-extended OR on lane A, illegal on lane B
      doReset(OpORI);
      for (int c = 0; c < 5; c++) begin
         if (c > 0) nextCycle();
         @(negedge clk);
         if (c == 2) begin
            check("ori_state", oA.st, ImmExec);
            check("ori_zext", oA.zext, 1);
            check("ori_aluop", oA.aluOp, ALUop_OR);
            check("ori_disabled_trap", oB.st, Trap);
            check("ori_disabled_illegal", oB.illegal, 1);
         end
         if (c == 3) check("ori_wrbck_regwe_rt", {oA.st, oA.regWe, oA.dstSel}, {ALURIWrbck, 2'b10});
         if (c == 4) check("ori_done", oA.st, Fetch);
      end

      // fetch timeout after TMO stalled cycles
      doReset(OpLW);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) nextCycle();
         rdy[0] = 1'b0;
         @(negedge clk);
         if (c == 7) check("tmo_pre_err", {oA.st, oA.memErr}, {Fetch, 1'b0});
         if (c == 8) check("tmo_err_trap", {oA.st, oA.memErr}, {Trap, 1'b1});
      end
      #2 rst_n = 1'b0;
      #1 check("tmo_async_clear", {oA.st, oA.memErr, oA.memReq}, {Fetch, 2'b00});

      // ready arriving on the last tolerated cycle wins
      doReset(OpLW);
      for (int c = 0; c < 9; c++) begin
         if (c > 0) nextCycle();
         rdy[0] = (c == 7);
         @(negedge clk);
         if (c == 7) check("tmo_edge_ir_we", oA.irWe, 1);
         if (c == 8) check("tmo_edge_decode", {oA.st, oA.memErr}, {Decode, 1'b0});
      end

      // unknown opcode traps and stays trapped
      doReset(6'b111111);
      for (int c = 0; c < 6; c++) begin
         if (c > 0) nextCycle();
         @(negedge clk);
         if (c == 2 || c == 5) check("illegal_trap", {oA.st, oA.illegal, oA.memReq}, {Trap, 2'b10});
      end
      #2 rst_n = 1'b0;
      #1 check("illegal_async_clear", {oA.st, oA.illegal}, {Fetch, 1'b0});

      // async reset in the middle of a stalled read
      doReset(OpLW);
      for (int c = 0; c < 4; c++) begin
         if (c > 0) nextCycle();
         rdy[0] = (c < 2);
      end
      #1 check("memrd_req_before_reset", {oA.st, oA.memReq}, {MemRd, 1'b1});
      rst_n = 1'b0;
      #1 check("memrd_req_dropped", {oA.st, oA.memReq, oA.memErr}, {Fetch, 2'b00});

      // randomized traffic on both lanes
      stall[0] = 0; stall[1] = 0; trapAge = 0;
      for (int c = 0; c < 3000; c++) begin
         nextCycle();
         if (!rst_n) rst_n = 1'b1;
         else if (mSt[0] == Trap || mSt[1] == Trap) begin
            trapAge++;
            if (trapAge >= 3) begin rst_n = 1'b0; trapAge = 0; end
         end
         for (int l = 0; l < 2; l++) begin
            if (mSt[l] == Fetch) opc[l] = pickOp(l);
            zr[l] = 1'($urandom_range(0, 1));
            if (stall[l] > 0) begin
               rdy[l] = 1'b0; stall[l]--;
            end else if ($urandom_range(0, 99) == 0) begin
               stall[l] = $urandom_range(6, 10); rdy[l] = 1'b0;
            end else begin
               rdy[l] = ($urandom_range(0, 3) != 0);
            end
         end
      end

      @(posedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
